// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions for the adder display path (encoder and capture receiver).
// Segment patterns are stored in active-high form, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b000_0000;

  // Index is the hex digit; entry 0 sits in the least significant slot.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b1110001, 7'b1111001, 7'b1011110, 7'b0111001,  // F E d C
    7'b1111100, 7'b1110111, 7'b1101111, 7'b1111111,  // b A 9 8
    7'b0000111, 7'b1111101, 7'b1101101, 7'b1100110,  // 7 6 5 4
    7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111   // 3 2 1 0
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACCEPT = 2'd2
  } state_t;

  typedef struct packed {
    logic       carry;
    logic [3:0] digit;
  } result_t;

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    return SEG_TABLE[digit];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment decoder: active-high pattern -> {hit, blank, digit}.
// A pattern that is neither a table entry nor blank reports hit=0, blank=0.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_pattern,
  output logic       o_hit,
  output logic       o_blank,
  output logic [3:0] o_digit
);

  logic [15:0] w_match;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_match
      assign w_match[gi] = (i_pattern == SEG_TABLE[gi]);
    end
  endgenerate

  always_comb begin
    o_digit = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (w_match[i]) o_digit = 4'(i);
    end
  end

  assign o_hit   = |w_match;
  assign o_blank = (i_pattern == SEG_BLANK);

endmodule

// File: rtl/seg7_capture_rx.sv
// Seven-segment capture receiver: samples the segment bus and carry, debounces with a stability
// counter, decodes to {carry, digit} and presents it on valid/ready. Optional stats: SEG7RX_STATS_EN.
module seg7_capture_rx
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       seg_in,
  input  logic             cout_in,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [4:0]       rx_data,
  output logic             illegal,
  output logic             overflow
`ifdef SEG7RX_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_accepts,
  output logic [CNT_W-1:0] stat_illegals
`endif
);

  if ((STABLE_CYCLES < 1) || (64'(STABLE_CYCLES) > ((64'd1 << CNT_W) - 64'd1))) begin : g_bad_cfg
    $error("seg7_capture_rx: STABLE_CYCLES must be in 1..2**CNT_W-1");
  end

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] STABLE_N = CNT_W'(STABLE_CYCLES);

  logic [7:0]       r_sample;
  logic [7:0]       r_cand;
  logic [CNT_W-1:0] r_cnt;
  state_t           r_state;
  result_t          r_last;
  logic             r_last_vld;
  logic             r_rx_valid;
  logic [4:0]       r_rx_data;
  logic             r_illegal;
  logic             r_overflow;

  logic             w_hit;
  logic             w_blank;
  logic [3:0]       w_digit;
  result_t          w_result;
  logic             w_emit;
  logic             w_load;
  logic             w_bad;
  logic [CNT_W-1:0] w_cnt_inc;
  state_t           w_after_load;

  seg7_decode u_decode (
    .i_pattern (r_cand[6:0]),
    .o_hit     (w_hit),
    .o_blank   (w_blank),
    .o_digit   (w_digit)
  );

  assign w_result     = '{carry: r_cand[7], digit: w_digit};
  assign w_emit       = (r_state == ACCEPT) && w_hit && (!r_last_vld || (w_result != r_last));
  assign w_bad        = (r_state == ACCEPT) && !w_hit && !w_blank;
  assign w_load       = w_emit && (!r_rx_valid || rx_ready);
  assign w_cnt_inc    = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_ONE;
  assign w_after_load = (STABLE_N == CNT_ONE) ? ACCEPT : SETTLE;

  // Carry is always active-high; only the segment bits follow ACTIVE_LOW.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sample <= 8'd0;
    end else begin
      r_sample <= {cout_in, (ACTIVE_LOW ? ~seg_in : seg_in)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cand     <= 8'd0;
      r_cnt      <= '0;
      r_last     <= '0;
      r_last_vld <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= 5'd0;
      r_illegal  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_sample != r_cand) begin
            r_cand  <= r_sample;
            r_cnt   <= CNT_ONE;
            r_state <= w_after_load;
          end
        end
        SETTLE: begin
          if (r_sample != r_cand) begin
            r_cand  <= r_sample;
            r_cnt   <= CNT_ONE;
            r_state <= w_after_load;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc >= STABLE_N) r_state <= ACCEPT;
          end
        end
        ACCEPT:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      r_illegal <= w_bad;

      // A same-cycle handshake frees the slot, so the new value slides in without a bubble.
      if (w_load) begin
        r_rx_data  <= w_result;
        r_rx_valid <= 1'b1;
        r_last     <= w_result;
        r_last_vld <= 1'b1;
      end else begin
        if (w_emit) r_overflow <= 1'b1;
        if (r_rx_valid && rx_ready) r_rx_valid <= 1'b0;
      end
    end
  end

`ifdef SEG7RX_STATS_EN
  logic [CNT_W-1:0] r_stat_acc;
  logic [CNT_W-1:0] r_stat_ill;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_acc <= '0;
      r_stat_ill <= '0;
    end else begin
      if (w_load && (r_stat_acc != {CNT_W{1'b1}})) r_stat_acc <= r_stat_acc + CNT_ONE;
      if (w_bad && (r_stat_ill != {CNT_W{1'b1}})) r_stat_ill <= r_stat_ill + CNT_ONE;
    end
  end

  assign stat_accepts  = r_stat_acc;
  assign stat_illegals = r_stat_ill;
`endif

  assign rx_valid = r_rx_valid;
  assign rx_data  = r_rx_data;
  assign illegal  = r_illegal;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_seg7_capture_rx.sv
// Directed self-checking bench for seg7_capture_rx with default parameters (active-low, 4 stable).
`timescale 1ns/1ps
module tb_seg7_capture_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg_in;
  logic       cout_in;
  logic       rx_ready;
  logic       rx_valid;
  logic [4:0] rx_data;
  logic       illegal;
  logic       overflow;
`ifdef SEG7RX_STATS_EN
  logic [7:0] stat_accepts;
  logic [7:0] stat_illegals;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  // Active-high gfedcba patterns for digits 0..F.
  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg7_capture_rx dut (
    .clk           (clk),
    .rst           (rst),
    .seg_in        (seg_in),
    .cout_in       (cout_in),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_data       (rx_data),
    .illegal       (illegal),
    .overflow      (overflow)
`ifdef SEG7RX_STATS_EN
    ,
    .stat_accepts  (stat_accepts),
    .stat_illegals (stat_illegals)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic show(input int digit, input logic carry);
    seg_in  = ~tbl[digit];
    cout_in = carry;
  endtask

  task automatic wait_valid(input int max, output int cyc);
    cyc = 0;
    while (!rx_valid && cyc < max) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, nv, ni;
    logic [4:0] dat;

    rst = 1'b1; seg_in = 7'h7F; cout_in = 1'b0; rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(rx_valid), 0);
    chk("rst_data", 32'(rx_data), 0);
    chk("rst_illegal", 32'(illegal), 0);
    chk("rst_overflow", 32'(overflow), 0);

    // First value after reset: active-low "0", carry 0.
    rst = 1'b0;
    seg_in = 7'b1000000;
    wait_valid(20, cyc);
    chk("first_latency", 32'(cyc), 6);
    chk("first_data", {rx_valid, rx_data}, {1'b1, 5'b00000});
    rx_ready = 1'b1;
    @(negedge clk);
    chk("first_consumed", 32'(rx_valid), 0);

    // Sum sweep A=B=n after a fresh reset so the n=0 result is a first value.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 16; n++) begin
      show((2 * n) % 16, n >= 8);
      wait_valid(20, cyc);
      chk($sformatf("sweep_%0d", n), {rx_valid, rx_data}, {1'b1, 1'(n >= 8), 4'((2 * n) % 16)});
      @(negedge clk);
    end
    chk("sweep_overflow", 32'(overflow), 0);

    // Glitch: "4" for 2 cycles then "5"; only 5 should come out.
    nv = 0; dat = 5'h1F;
    show(4, 1'b0);
    for (int i = 0; i < 14; i++) begin
      if (i == 2) show(5, 1'b0);
      @(negedge clk);
      if (rx_valid) begin nv++; dat = rx_data; end
    end
    chk("glitch_count", 32'(nv), 1);
    chk("glitch_data", 32'(dat), 32'h05);

    // Illegal pattern then blank.
    nv = 0; ni = 0;
    seg_in = 7'b0110110; cout_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rx_valid) nv++;
      if (illegal) ni++;
    end
    chk("illegal_pulses", 32'(ni), 1);
    chk("illegal_valid", 32'(nv), 0);
    nv = 0; ni = 0;
    seg_in = 7'b1111111;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rx_valid) nv++;
      if (illegal) ni++;
    end
    chk("blank_pulses", 32'(ni), 0);
    chk("blank_valid", 32'(nv), 0);

    // Backpressure: "3" held unconsumed, then "7" must be dropped.
    rx_ready = 1'b0;
    show(3, 1'b0);
    wait_valid(20, cyc);
    chk("bp_first", {rx_valid, rx_data}, {1'b1, 5'b00011});
    show(7, 1'b0);
    repeat (12) @(negedge clk);
    chk("bp_hold_data", 32'(rx_data), 32'h03);
    chk("bp_hold_valid", 32'(rx_valid), 1);
    chk("bp_overflow", 32'(overflow), 1);
    rx_ready = 1'b1;
    @(negedge clk);
    chk("bp_consumed", 32'(rx_valid), 0);
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rx_valid) nv++;
    end
    chk("bp_no_reemit", 32'(nv), 0);

    // Reset with a pending value and the FSM mid-settle.
    rx_ready = 1'b0;
    show(10, 1'b0);
    wait_valid(20, cyc);
    chk("rstmid_pre", {rx_valid, rx_data}, {1'b1, 5'b01010});
    show(2, 1'b0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rstmid_valid", 32'(rx_valid), 0);
    chk("rstmid_data", 32'(rx_data), 0);
    chk("rstmid_illegal", 32'(illegal), 0);
    chk("rstmid_overflow", 32'(overflow), 0);
    show(10, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_valid(20, cyc);
    chk("rstmid_after", {rx_valid, rx_data}, {1'b1, 5'b01010});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/seg7_capture_rx.md
Name: seg7_capture_rx

Overview:
- Receive side of the adder/seven-segment display path.
- Samples the 7-segment drive bus plus carry line and filters glitches with a stability counter.
- Decodes the pattern back to a 4-bit hex digit and presents the recovered 5-bit result {carry, digit} on a valid/ready interface.
- Used as a self-checking monitor and as the readback front end for the display path.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples required before a pattern is accepted (legal range 1..255).
- ACTIVE_LOW, 1: 1 means segment bits are active-low (0 = lit); 0 means active-high.
- CNT_W, 8: width of the stability counter and the optional statistics counters.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- seg_in  in  7  segment bus, bit order {g,f,e,d,c,b,a}
- cout_in  in  1  carry line sampled alongside seg_in
- rx_valid  out  1  recovered value available
- rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready
- rx_data  out  5  {carry, hex digit}
- illegal  out  1  one-cycle pulse when a stable, non-blank, undecodable pattern is accepted
- overflow  out  1  sticky; set when an accepted value is dropped; cleared only by rst

Behaviour:
- Reset values: rx_valid=0, rx_data=0, illegal=0, overflow=0; FSM=IDLE; stability counter=0; last-emitted register invalid.
- Input stage:
  - seg_in and cout_in are registered once into a 8-bit sample, inverted first when ACTIVE_LOW=1.
  - All decisions use the registered sample, so there is 1 cycle of input latency.
- Decode table (active-high form, gfedcba):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001
  - All-off (0000000) is BLANK. Every other pattern is ILLEGAL.
- FSM:
  - IDLE: sample differs from the held candidate → load candidate, counter=1, go to SETTLE.
  - SETTLE: each cycle the sample equals the candidate, counter++. Any mismatch reloads the candidate with counter=1 and stays in SETTLE. When counter reaches STABLE_CYCLES, go to ACCEPT.
  - ACCEPT (single cycle):
    - BLANK: no emission, no pulse.
    - ILLEGAL: illegal pulses for 1 cycle; no emission.
    - Legal and different from the last emitted {carry, digit}, or the first value since reset: emit.
    - Legal and equal to the last emitted value: no emission.
    - Then go to IDLE.
- Latency: from a stable input change to rx_valid=1 is 1 + STABLE_CYCLES + 1 cycles. With defaults this is 6.
- Emit when rx_valid=0: rx_data is loaded, rx_valid=1 on the next cycle, and the last-emitted register is updated.
- Emit when rx_valid=1 and no handshake this cycle: the new value is dropped, overflow sets, and the last-emitted register is unchanged.
- Emit in the same cycle as a handshake: the new value replaces the old, so there is no bubble and no overflow.
- rx_valid, once high, stays high with rx_data stable until the handshake. This must never be violated.
- rx_ready is ignored while rx_valid=0.
- Counter saturates and cannot wrap. The value STABLE_CYCLES ≤ 2^CNT_W−1 is enforced by elaboration check.
- rst asserted mid-SETTLE or with rx_valid=1 clears everything immediately; the pending value is lost.

Optional Feature:
- Macro: SEG7RX_STATS_EN.
- When defined, adds two outputs:
  - stat_accepts[CNT_W-1:0]: counts emitted values.
  - stat_illegals[CNT_W-1:0]: counts illegal pulses.
- Both counters saturate at all-ones and are cleared by rst.
- When undefined, neither port nor counter exists, and core behaviour is identical.

Decomposition:
- Package seg7_pkg holds:
  - the 16-entry segment constant table
  - SEG_BLANK
  - the FSM state enum (IDLE, SETTLE, ACCEPT)
  - the 5-bit result typedef
- The transmit-side encoder reuses the same package.
- Sub-module seg7_decode is purely combinational: pattern → {hit, blank, digit}. The FSM, counter and output register stay in seg7_capture_rx.

Test Plan:
- Reset release, then seg_in = 7'b1000000 (active-low "0") held with cout_in=0 → rx_valid rises 6 cycles after the first registered sample, rx_data=5'b00000.
- Sum sweep with A=B=n for n=0..15: segments for (2n mod 16) plus carry (n≥8) → rx_data sequence 00,02,04,…,0E,10,12,…,1E, each consumed with rx_ready=1, overflow=0.
- Glitch: "4" (0011001 active-low) held for 2 cycles then "5" (0010010) held for 10 cycles, STABLE_CYCLES=4 → only 5'b00101 is emitted.
- Illegal and blank: 7'b0110110 held 8 cycles → one illegal pulse, no rx_valid; 7'b1111111 (blank) held → no emission, no pulse.
- Backpressure: rx_ready=0, emit "3" then "7" → rx_data stays 00011, overflow=1; then rx_ready=1 → handshake, and the same "7" re-held without change is not re-emitted.
- Assert rst while in SETTLE with rx_valid=1 → all outputs 0 the same cycle; the next stable "A" is emitted as 5'b01010 (the first-after-reset rule applies).
